pipe_mem_arbiter: RTL

Shares the single Avalon-style memory port of the pipelined CPU between the instruction-fetch requester (IF stage, driven by the PC register) and the data-memory requester (MEM stage). It runs a three-state FSM, registers the bus request, and holds it stable while `waitrequest` is high. It returns captured read data with a one-cycle done pulse, and produces the per-requester stall lines the hazard unit uses to gate `PCWrite` and the pipeline registers.

---
 rtl/pipe_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_mem_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and data memory; request to done is 2 cycles minimum.
// Bus request is registered and held while waitrequest is high; requesters see stall until their done pulse.
module pipe_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_address,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_address,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_byteenable,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t state, state_nxt;
  logic   last_dm;
  logic   if_elig, dm_elig;
  logic   grant_if, grant_dm, complete;

  // A requester whose done pulse is showing is about to drop its request, so it is not eligible.
  always_comb begin
    if_elig   = if_req & ~if_done;
    dm_elig   = dm_req & ~dm_done;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    complete  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (if_elig && dm_elig) begin
          grant_if = last_dm;
          grant_dm = ~last_dm;
        end else begin
          grant_if = if_elig;
          grant_dm = dm_elig;
        end
        if (grant_dm)
          state_nxt = BUSY_DM;
        else if (grant_if)
          state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: begin
        if (!waitrequest) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      address    <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'h0;
      byteenable <= 4'h0;
      if_rdata   <= 32'h0;
      dm_rdata   <= 32'h0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      last_dm    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_if) begin
        address    <= if_address & 32'hFFFF_FFFC;
        read       <= 1'b1;
        write      <= 1'b0;
        byteenable <= 4'hF;
      end else if (grant_dm) begin
        address    <= dm_address & 32'hFFFF_FFFC;
        read       <= ~dm_we;
        write      <= dm_we;
        byteenable <= dm_byteenable;
        writedata  <= dm_wdata;
      end else if (complete) begin
        read    <= 1'b0;
        write   <= 1'b0;
        last_dm <= (state == BUSY_DM);
        // Address, write data and byte enables stay put so the idle bus does not toggle.
        if (state == BUSY_IF) begin
          if_done <= 1'b1;
          if (read)
            if_rdata <= readdata;
        end else begin
          dm_done <= 1'b1;
          if (read)
            dm_rdata <= readdata;
        end
      end
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule
